// File: rtl/add_op_serial_responder.sv
// Digit-serial unsigned adder behind a valid/ready request/response pair.
// One operand pair is in flight at a time; the result is held until the consumer takes it.
module add_op_serial_responder #(
    parameter int OPERAND_WIDTH = 32,
    parameter int DIGIT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [OPERAND_WIDTH-1:0] lhs,
    input  logic [OPERAND_WIDTH-1:0] rhs,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [OPERAND_WIDTH-1:0] result,
    output logic                     carry_out
);

    localparam int NUM_DIGITS = OPERAND_WIDTH / DIGIT_WIDTH;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (OPERAND_WIDTH % DIGIT_WIDTH != 0) begin : g_bad_digit_width
            $error("OPERAND_WIDTH must be a multiple of DIGIT_WIDTH");
        end
    endgenerate

    logic [1:0]               r_state;
    logic [OPERAND_WIDTH-1:0] r_lhs;
    logic [OPERAND_WIDTH-1:0] r_rhs;
    logic [OPERAND_WIDTH-1:0] r_result;
    logic                     r_carry;
    logic                     r_carry_out;
    logic [CNT_W-1:0]         r_cnt;

    logic [DIGIT_WIDTH:0]                   w_digit_sum;
    logic [OPERAND_WIDTH+DIGIT_WIDTH-1:0]   w_result_shift;

    assign w_digit_sum = {1'b0, r_lhs[DIGIT_WIDTH-1:0]}
                       + {1'b0, r_rhs[DIGIT_WIDTH-1:0]}
                       + {{DIGIT_WIDTH{1'b0}}, r_carry};

    // New digit enters at the MSB end; after N shifts the first digit sits at bit 0.
    // Building the wider vector keeps this legal when a single digit spans the operand.
    assign w_result_shift = {w_digit_sum[DIGIT_WIDTH-1:0], r_result};

    assign req_ready = (r_state == S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values, matching the hardware's simultaneous update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lhs       <= '0;
            r_rhs       <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_lhs   <= lhs;
                        r_rhs   <= rhs;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_lhs    <= r_lhs >> DIGIT_WIDTH;
                    r_rhs    <= r_rhs >> DIGIT_WIDTH;
                    r_result <= w_result_shift[OPERAND_WIDTH+DIGIT_WIDTH-1:DIGIT_WIDTH];
                    r_carry  <= w_digit_sum[DIGIT_WIDTH];
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_DIGIT) begin
                        r_carry_out <= w_digit_sum[DIGIT_WIDTH];
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_op_serial_responder.sv
// Scoreboard bench: a 4-digit instance (32/8) and a single-digit instance (32/32),
// checked against plain 33-bit addition, with directed corner cases and random back-to-back ops.
module tb_add_op_serial_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] lhs       [2];
    logic [31:0] rhs       [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic [31:0] result    [2];
    logic        carry_out [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];

    logic        prev_valid [2];
    logic        hs_prev    [2];
    logic [32:0] prev_out   [2];
    int          acc_cyc    [2];
    bit          rand_done;

    add_op_serial_responder #(.OPERAND_WIDTH(32), .DIGIT_WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .lhs       (lhs[0]),
        .rhs       (rhs[0]),
        .res_valid (res_valid[0]),
        .res_ready (res_ready[0]),
        .result    (result[0]),
        .carry_out (carry_out[0])
    );

    add_op_serial_responder #(.OPERAND_WIDTH(32), .DIGIT_WIDTH(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .lhs       (lhs[1]),
        .rhs       (rhs[1]),
        .res_valid (res_valid[1]),
        .res_ready (res_ready[1]),
        .result    (result[1]),
        .carry_out (carry_out[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout/unexpected required=event", name);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Monitor: samples on the falling edge; a handshake seen here completes on the next rising edge.
    initial begin
        for (int d = 0; d < 2; d++) begin
            prev_valid[d] = 1'b0;
            hs_prev[d]    = 1'b0;
            prev_out[d]   = '0;
            acc_cyc[d]    = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic        hs_now;
                logic [32:0] exp;
                int          ndig;
                ndig   = (d == 0) ? 4 : 1;
                hs_now = 1'b0;
                if (!rst_n) begin
                    prev_valid[d] = 1'b0;
                    hs_prev[d]    = 1'b0;
                    if (d == 0) q0.delete();
                    else q1.delete();
                end else begin
                    if (hs_prev[d]) begin
                        check_bit($sformatf("idle_after_hs[%0d]", d), req_ready[d], 1'b1);
                        check_bit($sformatf("valid_dropped[%0d]", d), res_valid[d], 1'b0);
                    end else if (prev_valid[d]) begin
                        check_bit($sformatf("valid_held[%0d]", d), res_valid[d], 1'b1);
                        check_word($sformatf("result_stable[%0d]", d),
                                   {carry_out[d], result[d]}, prev_out[d]);
                    end
                    if (res_valid[d] && !prev_valid[d]) begin
                        check_word($sformatf("latency[%0d]", d), 33'(cyc - acc_cyc[d]), 33'(ndig));
                    end
                    if (res_valid[d] && res_ready[d]) begin
                        hs_now = 1'b1;
                        if (qsize(d) == 0) begin
                            fail($sformatf("unexpected_result[%0d]", d));
                        end else begin
                            exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                            check_word($sformatf("carry_sum[%0d]", d), {carry_out[d], result[d]}, exp);
                        end
                    end
                    if (req_valid[d] && req_ready[d]) begin
                        exp = 33'(lhs[d]) + 33'(rhs[d]);
                        if (d == 0) q0.push_back(exp);
                        else q1.push_back(exp);
                        acc_cyc[d] = cyc + 1;
                    end
                    prev_valid[d] = res_valid[d];
                    prev_out[d]   = {carry_out[d], result[d]};
                    hs_prev[d]    = hs_now;
                end
            end
        end
    end

    // Holds the request until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        req_valid[d] = 1'b1;
        lhs[d]       = a;
        rhs[d]       = b;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = req_ready[d];
            n++;
            @(posedge clk);
            #1;
        end
        if (!ok) fail($sformatf("req_timeout[%0d]", d));
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while ((qsize(d) != 0 || res_valid[d]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail($sformatf("drain_timeout[%0d]", d));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          n;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            lhs[d]       = '0;
            rhs[d]       = '0;
            res_ready[d] = 1'b1;
        end

        // Reset state, then idle after release.
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_bit($sformatf("rst_req_ready[%0d]", d), req_ready[d], 1'b1);
            check_bit($sformatf("rst_res_valid[%0d]", d), res_valid[d], 1'b0);
            check_word($sformatf("rst_outputs[%0d]", d), {carry_out[d], result[d]}, 33'd0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_bit($sformatf("idle_req_ready[%0d]", d), req_ready[d], 1'b1);
            check_bit($sformatf("idle_res_valid[%0d]", d), res_valid[d], 1'b0);
        end

        // Small add, then carry ripple through every digit.
        send(0, 32'h0000_0003, 32'h0000_0004);
        wait_drain(0);
        send(0, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_drain(0);

        // Backpressure: result held, new request refused while DONE.
        res_ready[0] = 1'b0;
        send(0, 32'h8000_0000, 32'h8000_0000);
        n = 0;
        while (!res_valid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("done_timeout");
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        lhs[0]       = 32'hA5A5_A5A5;
        rhs[0]       = 32'h5A5A_5A5A;
        repeat (5) begin
            @(negedge clk);
            check_bit("req_ready_in_done", req_ready[0], 1'b0);
            check_bit("res_valid_held", res_valid[0], 1'b1);
        end
        @(posedge clk);
        #1;
        res_ready[0] = 1'b1;
        send(0, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        wait_drain(0);

        // Reset during the second BUSY cycle aborts the op.
        send(0, 32'h0000_0001, 32'h0000_0002);
        @(posedge clk);
        #1;
        #2 rst_n = 1'b0;
        #1;
        check_bit("abort_req_ready", req_ready[0], 1'b1);
        check_bit("abort_res_valid", res_valid[0], 1'b0);
        check_word("abort_outputs", {carry_out[0], result[0]}, 33'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 32'h1234_5678, 32'h1111_1111);
        wait_drain(0);

        // Single-digit instance.
        send(1, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_drain(1);

        // Random back-to-back ops with random consumer stalls.
        for (int d = 0; d < 2; d++) begin
            rand_done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 40; i++) begin
                        a = $urandom;
                        b = $urandom;
                        case ($urandom_range(0, 4))
                            0: a = 32'hFFFF_FFFF;
                            1: b = ~a;
                            2: b = 32'h0000_0000;
                            default: ;
                        endcase
                        send(d, a, b);
                        if ($urandom_range(0, 3) == 0) begin
                            repeat ($urandom_range(1, 3)) begin
                                @(posedge clk);
                                #1;
                            end
                        end
                    end
                    rand_done = 1'b1;
                end
                begin
                    while (!rand_done) begin
                        @(posedge clk);
                        #1;
                        res_ready[d] = ($urandom_range(0, 2) != 0);
                    end
                end
            join
            res_ready[d] = 1'b1;
            wait_drain(d);
        end

        check_word("q0_empty", 33'(q0.size()), 33'd0);
        check_word("q1_empty", 33'(q1.size()), 33'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
